// File: rtl/sram_rd_ctrl.sv
// AHB-Lite read-only front end for a single-port synchronous SRAM with byte/half/word lane masking.
// Optional macro SRAM_RD_WAIT_EN adds one wait state and registers the read data.
module sram_rd_ctrl #(
  parameter int ADDR_W = 12
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              hsel,
  input  logic [1:0]        htrans,
  input  logic              hready,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic [31:0]       haddr,
  output logic [31:0]       hrdata,
  output logic              hreadyout,
  output logic [1:0]        hresp,
  output logic              sram_cen,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [31:0]       sram_rdata
);

  typedef enum logic [2:0] {IDLE, READ, WAIT, ERR1, ERR2} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_size;
  logic [1:0]  r_off;
  logic        w_accept;
  logic        w_misalign;
  logic        w_rd_ok;
  logic        w_unused;

  function automatic logic [31:0] lane_mask(input logic [31:0] d,
                                            input logic [1:0]  sz,
                                            input logic [1:0]  off);
    logic [31:0] m;
    case (sz)
      2'b00:   m = 32'h0000_00FF << {off, 3'b000};
      2'b01:   m = off[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
      default: m = 32'hFFFF_FFFF;
    endcase
    return d & m;
  endfunction

  assign hreadyout  = !(r_state == ERR1 || r_state == WAIT);
  assign w_accept   = hsel & htrans[1] & hready & !hwrite & hreadyout;
  assign w_misalign = (hsize == 3'b001 && haddr[0]) ||
                      (hsize == 3'b010 && haddr[1:0] != 2'b00) ||
                      (hsize > 3'b010);
  assign w_rd_ok    = w_accept & !w_misalign;
  assign sram_cen   = !(w_rd_ok & hresetn);
  assign sram_addr  = haddr[ADDR_W+1:2];
  assign w_unused   = &{1'b0, haddr[31:ADDR_W+2], htrans[0]};

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      r_state <= IDLE;
      r_size  <= 2'b00;
      r_off   <= 2'b00;
    end else begin
      r_state <= w_next;
      if (w_rd_ok) begin
        r_size <= hsize[1:0];
        r_off  <= haddr[1:0];
      end
    end
  end

`ifdef SRAM_RD_WAIT_EN
  logic [31:0] r_rdata;

  // WAIT is the cycle the SRAM output is valid; capture it so READ can present it.
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      r_rdata <= 32'h0;
    end else if (r_state == WAIT) begin
      r_rdata <= lane_mask(sram_rdata, r_size, r_off);
    end
  end
`endif

  always_comb begin
    w_next = IDLE;
    hresp  = 2'b00;
    hrdata = 32'h0;
    case (r_state)
      ERR1: begin
        hresp  = 2'b01;
        w_next = ERR2;
      end
`ifdef SRAM_RD_WAIT_EN
      WAIT: w_next = READ;
`endif
      default: begin
        if (r_state == ERR2) hresp = 2'b01;
        if (r_state == READ) begin
`ifdef SRAM_RD_WAIT_EN
          hrdata = r_rdata;
`else
          hrdata = lane_mask(sram_rdata, r_size, r_off);
`endif
        end
        if (w_accept) begin
          if (w_misalign) begin
            w_next = ERR1;
          end else begin
`ifdef SRAM_RD_WAIT_EN
            w_next = WAIT;
`else
            w_next = READ;
`endif
          end
        end
      end
    endcase
  end

endmodule

// File: tb/tb_sram_rd_ctrl.sv
// Directed bench for sram_rd_ctrl: reset, lane masking, misalignment errors, back-to-back and reset abort.
module tb_sram_rd_ctrl;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        hsel;
  logic [1:0]  htrans;
  logic        hready;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] haddr;
  logic [31:0] hrdata;
  logic        hreadyout;
  logic [1:0]  hresp;
  logic        sram_cen;
  logic [11:0] sram_addr;
  logic [31:0] sram_rdata;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  sram_rd_ctrl #(.ADDR_W(12)) dut (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel), .htrans(htrans), .hready(hready),
    .hwrite(hwrite), .hsize(hsize), .haddr(haddr), .hrdata(hrdata),
    .hreadyout(hreadyout), .hresp(hresp), .sram_cen(sram_cen),
    .sram_addr(sram_addr), .sram_rdata(sram_rdata)
  );

  always #5 hclk = ~hclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    hsel = 1'b0; htrans = 2'b00; hready = 1'b1; hwrite = 1'b0; hsize = 3'b010; haddr = 32'h0;
  endtask

  task automatic rd(input logic [2:0] sz, input logic [31:0] a);
    hsel = 1'b1; htrans = 2'b10; hready = 1'b1; hwrite = 1'b0; hsize = sz; haddr = a;
  endtask

  task automatic next_cyc();
    @(posedge hclk);
    #1;
  endtask

  // Entered and left one time unit after a rising edge.
  task automatic read_check(input string tag, input logic [2:0] sz, input logic [31:0] a,
                            input logic [31:0] d, input logic [31:0] exp);
    rd(sz, a);
    #3;
    chk({tag, "_cen"}, {31'b0, sram_cen}, 32'h0);
    chk({tag, "_addr"}, {20'b0, sram_addr}, {20'b0, a[13:2]});
    next_cyc();
    idle_in();
    sram_rdata = d;
`ifdef SRAM_RD_WAIT_EN
    #3;
    chk({tag, "_wait_rdy"}, {31'b0, hreadyout}, 32'h0);
    next_cyc();
    sram_rdata = ~d;
`endif
    #3;
    chk({tag, "_data"}, hrdata, exp);
    chk({tag, "_rdy"}, {31'b0, hreadyout}, 32'h1);
    chk({tag, "_resp"}, {30'b0, hresp}, 32'h0);
    next_cyc();
  endtask

  initial begin
    idle_in();
    sram_rdata = 32'hFFFF_FFFF;
    hresetn = 1'b0;
    rd(3'b010, 32'h10);
    #1;
    chk("rst_cen_async", {31'b0, sram_cen}, 32'h1);
    next_cyc();
    #3;
    chk("rst_cen", {31'b0, sram_cen}, 32'h1);
    chk("rst_rdy", {31'b0, hreadyout}, 32'h1);
    chk("rst_resp", {30'b0, hresp}, 32'h0);
    chk("rst_data", hrdata, 32'h0);
    next_cyc();
    hresetn = 1'b1;
    idle_in();

    read_check("word10", 3'b010, 32'h10, 32'hA1B2_C3D4, 32'hA1B2_C3D4);
    read_check("byte13", 3'b000, 32'h13, 32'h1122_3344, 32'h1100_0000);
    read_check("half12", 3'b001, 32'h12, 32'h1122_3344, 32'h1122_0000);
    read_check("byte11", 3'b000, 32'h11, 32'h1122_3344, 32'h0000_3300);
    read_check("half10", 3'b001, 32'h10, 32'h1122_3344, 32'h0000_3344);
    read_check("word20", 3'b010, 32'h20, 32'hCAFE_F00D, 32'hCAFE_F00D);

    // Misaligned word: two-cycle ERROR, a request during ERR1 must be ignored.
    rd(3'b010, 32'h02);
    #3;
    chk("mis_cen", {31'b0, sram_cen}, 32'h1);
    next_cyc();
    rd(3'b010, 32'h40);
    sram_rdata = 32'h5555_AAAA;
    #3;
    chk("err1_rdy", {31'b0, hreadyout}, 32'h0);
    chk("err1_resp", {30'b0, hresp}, 32'h1);
    chk("err1_data", hrdata, 32'h0);
    chk("err1_cen", {31'b0, sram_cen}, 32'h1);
    next_cyc();
    idle_in();
    #3;
    chk("err2_rdy", {31'b0, hreadyout}, 32'h1);
    chk("err2_resp", {30'b0, hresp}, 32'h1);
    chk("err2_data", hrdata, 32'h0);
    next_cyc();
    #3;
    chk("post_err_resp", {30'b0, hresp}, 32'h0);
    next_cyc();

    // Size 011 is always an error.
    rd(3'b011, 32'h0);
    #3;
    chk("sz3_cen", {31'b0, sram_cen}, 32'h1);
    next_cyc();
    idle_in();
    #3;
    chk("sz3_resp", {30'b0, hresp}, 32'h1);
    next_cyc();
    next_cyc();

    // Writes and BUSY are answered OKAY with no SRAM access.
    rd(3'b010, 32'h10);
    hwrite = 1'b1;
    #3;
    chk("wr_cen", {31'b0, sram_cen}, 32'h1);
    next_cyc();
    idle_in();
    #3;
    chk("wr_data", hrdata, 32'h0);
    chk("wr_rdy", {31'b0, hreadyout}, 32'h1);
    next_cyc();
    rd(3'b010, 32'h10);
    htrans = 2'b01;
    #3;
    chk("busy_cen", {31'b0, sram_cen}, 32'h1);
    next_cyc();
    idle_in();

`ifndef SRAM_RD_WAIT_EN
    // Back-to-back words 0x0, 0x4, 0x8.
    rd(3'b010, 32'h0);
    #3;
    chk("b2b0_cen", {31'b0, sram_cen}, 32'h0);
    next_cyc();
    rd(3'b010, 32'h4);
    sram_rdata = 32'hD000_0000;
    #3;
    chk("b2b0_data", hrdata, 32'hD000_0000);
    chk("b2b0_rdy", {31'b0, hreadyout}, 32'h1);
    chk("b2b1_cen", {31'b0, sram_cen}, 32'h0);
    chk("b2b1_addr", {20'b0, sram_addr}, 32'h1);
    next_cyc();
    rd(3'b010, 32'h8);
    sram_rdata = 32'hD111_1111;
    #3;
    chk("b2b1_data", hrdata, 32'hD111_1111);
    chk("b2b1_rdy", {31'b0, hreadyout}, 32'h1);
    chk("b2b2_addr", {20'b0, sram_addr}, 32'h2);
    next_cyc();
    idle_in();
    sram_rdata = 32'hD222_2222;
    #3;
    chk("b2b2_data", hrdata, 32'hD222_2222);
    chk("b2b2_rdy", {31'b0, hreadyout}, 32'h1);
    next_cyc();
    #3;
    chk("b2b_idle_data", hrdata, 32'h0);
    next_cyc();

    // Reset while in READ abandons the transfer.
    rd(3'b010, 32'h10);
    next_cyc();
    idle_in();
    sram_rdata = 32'h1234_5678;
    hresetn = 1'b0;
    next_cyc();
    #3;
    chk("rst_read_rdy", {31'b0, hreadyout}, 32'h1);
    chk("rst_read_data", hrdata, 32'h0);
    next_cyc();
    hresetn = 1'b1;
`else
    // Reset while in WAIT returns to IDLE.
    rd(3'b010, 32'h24);
    next_cyc();
    idle_in();
    sram_rdata = 32'h1234_5678;
    hresetn = 1'b0;
    next_cyc();
    #3;
    chk("rst_wait_rdy", {31'b0, hreadyout}, 32'h1);
    chk("rst_wait_data", hrdata, 32'h0);
    next_cyc();
    hresetn = 1'b1;
    next_cyc();
    #3;
    chk("post_rst_data", hrdata, 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sram_rd_ctrl.md
SRAM_RD_CTRL -- requirements
Module: sram_rd_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, SRAM word-address width.
REQ-002 SHALL have port hclk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port hresetn  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port hsel  input  1  AHB slave select.
REQ-005 SHALL have port htrans  input  2  AHB transfer type.
REQ-006 SHALL have port hready  input  1  AHB bus ready (previous data phase complete).
REQ-007 SHALL have port hwrite  input  1  AHB write (1) / read (0).
REQ-008 SHALL have port hsize  input  3  AHB access size: 000 byte, 001 half-word, 010 word.
REQ-009 SHALL have port haddr  input  32  AHB byte address.
REQ-010 SHALL have port hrdata  output  32  AHB read data.
REQ-011 SHALL have port hreadyout  output  1  slave ready.
REQ-012 SHALL have port hresp  output  2  00 OKAY, 01 ERROR.
REQ-013 SHALL have port sram_cen  output  1  SRAM chip enable, active-low.
REQ-014 SHALL have port sram_addr  output  ADDR_W  SRAM word address.
REQ-015 SHALL have port sram_rdata  input  32  SRAM read data, valid the cycle after the sram_cen=0 edge.

Function
REQ-016 SHALL accept a read when hsel & htrans[1] & hready & !hwrite & hreadyout.
REQ-017 SHALL treat an accepted read as misaligned if hsize=001 & haddr[0]=1, hsize=010 & haddr[1:0]!=00, or hsize>010.
REQ-018 SHALL, for an aligned accepted read, drive sram_cen=0 and sram_addr=haddr[ADDR_W+1:2] combinationally in the address-phase cycle; sram_cen=1 otherwise.
REQ-019 SHALL implement states IDLE, READ, WAIT, ERR1, ERR2.
REQ-020 SHALL transition: aligned accept -> READ (or WAIT with macro); misaligned accept -> ERR1; ERR1 -> ERR2; otherwise from READ/ERR2 -> IDLE.
REQ-021 SHALL in READ drive hreadyout=1, hresp=00, hrdata=lane-masked sram_rdata (zero wait states, 1-cycle data phase).
REQ-022 SHALL lane-mask: byte keeps lane haddr[1:0] (lane 0 = bits 7:0); half-word keeps lanes {haddr[1],0} and {haddr[1],1}; word keeps all; unselected bits driven 0; size/offset registered at accept.
REQ-023 SHALL in ERR1 drive hreadyout=0, hresp=01; in ERR2 drive hreadyout=1, hresp=01; no SRAM access for errored transfers.
REQ-024 SHALL ignore address-phase inputs while hreadyout=0 (ERR1, WAIT).
REQ-025 SHALL support back-to-back reads: a new accept in READ or ERR2 starts the next transfer with no idle cycle.
REQ-026 SHALL answer writes, IDLE and BUSY transfers with hreadyout=1, hresp=00, hrdata=0, sram_cen=1 (write path handled elsewhere).
REQ-027 SHALL drive hrdata=0 in IDLE, ERR1, ERR2.

Reset
REQ-028 SHALL, while hresetn=0 at a rising edge, enter IDLE, clear size/offset/data registers, hold hreadyout=1, hresp=00, hrdata=0.
REQ-029 SHALL force sram_cen=1 whenever hresetn=0; reset mid-transfer abandons it with no response.

Configuration
REQ-030 SHALL, with SRAM_RD_WAIT_EN defined, insert WAIT: hreadyout=0 first data-phase cycle while capturing lane-masked sram_rdata, then READ presenting the registered data with hreadyout=1.
REQ-031 SHALL, without SRAM_RD_WAIT_EN, never enter WAIT and contain no read-data register.

Verification
REQ-032 Word read haddr=0x10, sram_rdata=0xA1B2C3D4 -> sram_cen=0, sram_addr=4; next cycle hrdata=0xA1B2C3D4, hreadyout=1, hresp=00.
REQ-033 Byte read haddr=0x13, sram_rdata=0x11223344 -> hrdata=0x11000000; half-word haddr=0x12 -> hrdata=0x11220000.
REQ-034 Word read haddr=0x02 -> no sram_cen; hreadyout 0 then 1, hresp 01 both cycles, hrdata=0.
REQ-035 Three back-to-back word reads 0x0,0x4,0x8 -> three consecutive data phases, hreadyout=1 throughout.
REQ-036 SRAM_RD_WAIT_EN defined, word read 0x20 -> hreadyout=0 one cycle, then data with hreadyout=1; hresetn=0 during WAIT -> IDLE, hreadyout=1, hrdata=0.
